// File: rtl/reg_writeback_unit.sv
// Write-back buffer in front of the register file: queues ALU/load results in order,
// drains one per cycle, and forwards pending values to the two operand read ports.
module reg_writeback_unit #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_alu_valid,
  input  logic [ADDR_W-1:0] in_alu_dest,
  input  logic [DATA_W-1:0] in_alu_val,
  input  logic              in_mem_valid,
  input  logic [ADDR_W-1:0] in_mem_dest,
  input  logic [DATA_W-1:0] in_mem_val,
  input  logic [ADDR_W-1:0] in_read_reg_1_add,
  input  logic [ADDR_W-1:0] in_read_reg_2_add,
  input  logic [DATA_W-1:0] in_reg_1_val,
  input  logic [DATA_W-1:0] in_reg_2_val,
  output logic [ADDR_W-1:0] out_write_reg_add,
  output logic [DATA_W-1:0] out_write_reg_val,
  output logic              out_write_en,
  output logic [DATA_W-1:0] out_fwd_1_val,
  output logic [DATA_W-1:0] out_fwd_2_val,
  output logic              out_stall,
  output logic              out_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] dest_q [DEPTH];
  logic [DATA_W-1:0] val_q  [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              overflow;

  logic              pop;
  logic [CNT_W-1:0]  free;
  logic              alu_acc;
  logic              mem_acc;
  logic [PTR_W-1:0]  mem_slot;
  logic [PTR_W-1:0]  idx;

  // The head always drains this edge, so its slot is already free for incoming requests.
  always_comb begin
    pop      = (count != '0);
    free     = CNT_W'(DEPTH) - count + CNT_W'(pop);
    alu_acc  = in_alu_valid && (free != '0);
    mem_acc  = in_mem_valid && (free > CNT_W'(alu_acc));
    mem_slot = alu_acc ? wr_ptr + PTR_W'(1) : wr_ptr;
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        dest_q[i] <= '0;
        val_q[i]  <= '0;
      end
    end else begin
      if (alu_acc) begin
        dest_q[wr_ptr] <= in_alu_dest;
        val_q[wr_ptr]  <= in_alu_val;
      end
      if (mem_acc) begin
        dest_q[mem_slot] <= in_mem_dest;
        val_q[mem_slot]  <= in_mem_val;
      end
      if ((in_alu_valid && !alu_acc) || (in_mem_valid && !mem_acc)) begin
        overflow <= 1'b1;
      end
      rd_ptr <= rd_ptr + PTR_W'(pop);
      wr_ptr <= wr_ptr + PTR_W'(alu_acc) + PTR_W'(mem_acc);
      count  <= count - CNT_W'(pop) + CNT_W'(alu_acc) + CNT_W'(mem_acc);
    end
  end

  always_comb begin
    out_write_en      = pop;
    out_write_reg_add = pop ? dest_q[rd_ptr] : '0;
    out_write_reg_val = pop ? val_q[rd_ptr] : '0;
    out_stall         = (CNT_W'(DEPTH) - count) < CNT_W'(2);
    out_overflow      = overflow;
  end

  // Walk oldest to newest so that the last match, the youngest write, wins.
  always_comb begin
    out_fwd_1_val = in_reg_1_val;
    out_fwd_2_val = in_reg_2_val;
    idx           = rd_ptr;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PTR_W'(k);
      if (k < int'(count)) begin
        if (dest_q[idx] == in_read_reg_1_add) out_fwd_1_val = val_q[idx];
        if (dest_q[idx] == in_read_reg_2_add) out_fwd_2_val = val_q[idx];
      end
    end
  end

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Directed bench for reg_writeback_unit: hand-computed write-port, stall,
// overflow and forwarding values for a DEPTH=4 buffer.
module tb_reg_writeback_unit;

  logic        in_clk;
  logic        in_rst;
  logic        in_alu_valid;
  logic [7:0]  in_alu_dest;
  logic [15:0] in_alu_val;
  logic        in_mem_valid;
  logic [7:0]  in_mem_dest;
  logic [15:0] in_mem_val;
  logic [7:0]  in_read_reg_1_add;
  logic [7:0]  in_read_reg_2_add;
  logic [15:0] in_reg_1_val;
  logic [15:0] in_reg_2_val;
  logic [7:0]  out_write_reg_add;
  logic [15:0] out_write_reg_val;
  logic        out_write_en;
  logic [15:0] out_fwd_1_val;
  logic [15:0] out_fwd_2_val;
  logic        out_stall;
  logic        out_overflow;

  int total;
  int bad;

  reg_writeback_unit #(.DATA_W(16), .ADDR_W(8), .DEPTH(4)) dut (
    .in_clk(in_clk),
    .in_rst(in_rst),
    .in_alu_valid(in_alu_valid),
    .in_alu_dest(in_alu_dest),
    .in_alu_val(in_alu_val),
    .in_mem_valid(in_mem_valid),
    .in_mem_dest(in_mem_dest),
    .in_mem_val(in_mem_val),
    .in_read_reg_1_add(in_read_reg_1_add),
    .in_read_reg_2_add(in_read_reg_2_add),
    .in_reg_1_val(in_reg_1_val),
    .in_reg_2_val(in_reg_2_val),
    .out_write_reg_add(out_write_reg_add),
    .out_write_reg_val(out_write_reg_val),
    .out_write_en(out_write_en),
    .out_fwd_1_val(out_fwd_1_val),
    .out_fwd_2_val(out_fwd_2_val),
    .out_stall(out_stall),
    .out_overflow(out_overflow)
  );

  initial begin
    in_clk = 1'b0;
    forever #5 in_clk = ~in_clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic av, input logic [7:0] ad, input logic [15:0] aval,
                               input logic mv, input logic [7:0] md, input logic [15:0] mval);
    in_alu_valid = av;
    in_alu_dest  = ad;
    in_alu_val   = aval;
    in_mem_valid = mv;
    in_mem_dest  = md;
    in_mem_val   = mval;
    #1;
  endtask

  task automatic step();
    @(posedge in_clk);
    #1;
  endtask

  task automatic checkHead(input string tag, input logic en, input logic [7:0] add, input logic [15:0] val);
    checkOutput({tag, "_en"}, 32'(out_write_en), 32'(en));
    checkOutput({tag, "_add"}, 32'(out_write_reg_add), 32'(add));
    checkOutput({tag, "_val"}, 32'(out_write_reg_val), 32'(val));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    in_rst = 1'b1;
    in_read_reg_1_add = 8'd0;
    in_read_reg_2_add = 8'd0;
    in_reg_1_val = 16'h0;
    in_reg_2_val = 16'h0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    step();
    step();
    in_rst = 1'b0;
    #1;
    checkHead("rst", 0, 8'd0, 16'h0);
    checkOutput("rst_stall", 32'(out_stall), 32'd0);
    checkOutput("rst_ovf", 32'(out_overflow), 32'd0);

    // single ALU write-back
    applyStimulus(1, 8'd5, 16'h1234, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkHead("t1_head", 1, 8'd5, 16'h1234);
    step();
    checkOutput("t1_empty_en", 32'(out_write_en), 32'd0);

    // dual request in one cycle: ALU first
    applyStimulus(1, 8'd3, 16'h00AA, 1, 8'd7, 16'hBEEF);
    checkOutput("t2_stall_in", 32'(out_stall), 32'd0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkHead("t2_first", 1, 8'd3, 16'h00AA);
    checkOutput("t2_stall_c2", 32'(out_stall), 32'd0);
    step();
    checkHead("t2_second", 1, 8'd7, 16'hBEEF);
    checkOutput("t2_stall_c1", 32'(out_stall), 32'd0);
    step();
    checkOutput("t2_empty_en", 32'(out_write_en), 32'd0);

    // four cycles of dual requests fill the buffer and drop the last mem request
    applyStimulus(1, 8'h11, 16'hA001, 1, 8'h21, 16'hB001);
    step();
    checkOutput("t3_stall_c2", 32'(out_stall), 32'd0);
    applyStimulus(1, 8'h12, 16'hA002, 1, 8'h22, 16'hB002);
    step();
    checkOutput("t3_stall_c3", 32'(out_stall), 32'd1);
    checkOutput("t3_ovf_c3", 32'(out_overflow), 32'd0);
    applyStimulus(1, 8'h13, 16'hA003, 1, 8'h23, 16'hB003);
    step();
    checkOutput("t3_stall_c4", 32'(out_stall), 32'd1);
    checkOutput("t3_ovf_c4", 32'(out_overflow), 32'd0);
    applyStimulus(1, 8'h14, 16'hA004, 1, 8'h24, 16'hB004);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t3_ovf_set", 32'(out_overflow), 32'd1);
    checkHead("t3_d0", 1, 8'h22, 16'hB002);
    step();
    checkHead("t3_d1", 1, 8'h13, 16'hA003);
    step();
    checkHead("t3_d2", 1, 8'h23, 16'hB003);
    step();
    checkHead("t3_d3", 1, 8'h14, 16'hA004);
    step();
    checkHead("t3_done", 0, 8'h00, 16'h0000);
    checkOutput("t3_ovf_sticky", 32'(out_overflow), 32'd1);

    // reset with three entries pending discards them
    applyStimulus(1, 8'h31, 16'hC001, 1, 8'h32, 16'hC002);
    step();
    applyStimulus(1, 8'h33, 16'hC003, 1, 8'h34, 16'hC004);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t6_pre_stall", 32'(out_stall), 32'd1);
    in_rst = 1'b1;
    step();
    in_rst = 1'b0;
    #1;
    checkHead("t6_after", 0, 8'h00, 16'h0000);
    checkOutput("t6_stall", 32'(out_stall), 32'd0);
    checkOutput("t6_ovf", 32'(out_overflow), 32'd0);
    step();
    checkOutput("t6_still_empty", 32'(out_write_en), 32'd0);

    // forwarding: newest pending write to the same register wins
    in_read_reg_1_add = 8'd9;
    in_reg_1_val = 16'h0000;
    in_read_reg_2_add = 8'd4;
    in_reg_2_val = 16'h5A5A;
    applyStimulus(1, 8'd9, 16'h1111, 1, 8'd9, 16'h2222);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t4_fwd_both", 32'(out_fwd_1_val), 32'h2222);
    checkHead("t4_head0", 1, 8'd9, 16'h1111);
    checkOutput("t4_fwd2_pass", 32'(out_fwd_2_val), 32'h5A5A);
    step();
    checkOutput("t4_fwd_one", 32'(out_fwd_1_val), 32'h2222);
    checkHead("t4_head1", 1, 8'd9, 16'h2222);
    step();
    checkOutput("t4_fwd_empty", 32'(out_fwd_1_val), 32'h0000);
    in_reg_1_val = 16'h0F0F;
    #1;
    checkOutput("t4_fwd_pass", 32'(out_fwd_1_val), 32'h0F0F);

    // same-cycle request is not forwarded, but is once buffered
    applyStimulus(1, 8'd4, 16'h7777, 0, 0, 0);
    checkOutput("t5_same_cycle", 32'(out_fwd_2_val), 32'h5A5A);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t5_pending", 32'(out_fwd_2_val), 32'h7777);
    checkOutput("t5_fwd1_pass", 32'(out_fwd_1_val), 32'h0F0F);
    step();
    checkOutput("t5_drained", 32'(out_fwd_2_val), 32'h5A5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_writeback_unit.md
Name: reg_writeback_unit

Overview:
- Producer-side driver of the register file write port: collects write-back requests from the ALU and the memory-load path and buffers them in a small in-order FIFO.
- Drains one entry per cycle onto the register file write port.
- Forwards still-pending values to the two register file read ports, so operand reads never return stale data.
- Sits between execute/memory stages and the register file.

Parameters:
DATA_W, 16, register value width
ADDR_W, 8, register address width (256 registers)
DEPTH, 4, FIFO entries; power of two, minimum 2

Ports:
in_clk  input  1  clock, all state on rising edge
in_rst  input  1  synchronous reset, active-high
in_alu_valid  input  1  ALU write-back request
in_alu_dest  input  ADDR_W  ALU destination register
in_alu_val  input  DATA_W  ALU result
in_mem_valid  input  1  load write-back request
in_mem_dest  input  ADDR_W  load destination register
in_mem_val  input  DATA_W  load data
in_read_reg_1_add  input  ADDR_W  operand 1 address (shared with register file)
in_read_reg_2_add  input  ADDR_W  operand 2 address (shared with register file)
in_reg_1_val  input  DATA_W  register file read value 1
in_reg_2_val  input  DATA_W  register file read value 2
out_write_reg_add  output  ADDR_W  register file write address
out_write_reg_val  output  DATA_W  register file write data
out_write_en  output  1  register file write enable
out_fwd_1_val  output  DATA_W  forwarded operand 1
out_fwd_2_val  output  DATA_W  forwarded operand 2
out_stall  output  1  producers must hold off
out_overflow  output  1  sticky: request dropped

Behaviour:
- State: DEPTH-entry circular buffer of {dest, val}; rd_ptr, wr_ptr (log2 DEPTH bits, wrap modulo DEPTH); count (0..DEPTH); overflow flag.
- Reset (in_rst=1 at rising edge): count=0, pointers=0, overflow=0, entry contents cleared to 0.
  - After reset: out_write_en=0, out_write_reg_add=0, out_write_reg_val=0, out_stall=0, out_overflow=0.
- Write port is combinational from the FIFO head:
  - out_write_en = (count != 0).
  - out_write_reg_add/val = head entry when count != 0; 0 when empty.
  - The register file captures the write at the next edge. The head pops on that same edge, so drain rate is 1 entry/cycle and there is no backpressure from the register file.
- Enqueue, per rising edge:
  - If both valid: ALU entry written first (older), mem entry second.
  - Free slots are computed after this edge's pop: free = DEPTH - count + (count != 0).
  - A request that does not fit is dropped and overflow is set; overflow clears only on reset.
  - next count = count - pop + accepted.
- out_stall = (DEPTH - count) < 2, combinational. Producers must not assert valid while out_stall=1, though accepted-if-fits still applies.
- Forwarding, combinational, per read port:
  - Search FIFO entries newest to oldest for dest == read address; the newest match wins.
  - No match: pass through in_reg_x_val.
  - The head entry being written this cycle is included, because the register file shows the old value until the edge.
  - Same-cycle incoming requests (in_alu/in_mem) are NOT forwarded; the hazard unit handles them by stalling one cycle.
- Same address written twice in the FIFO: both writes reach the register file in order, so the final value is the younger one.
- Register 0 has no special treatment.
- Reset mid-operation: pending entries are discarded and not written to the register file.

Test Plan:
1. Reset, then ALU valid, dest=5, val=0x1234, single cycle -> next cycle out_write_en=1, add=5, val=0x1234; following cycle out_write_en=0, count=0.
2. ALU {3,0x00AA} and mem {7,0xBEEF} in the same cycle -> write port shows add=3 then add=7 on consecutive cycles; out_stall stays 0.
3. Both sources valid for 3 consecutive cycles (DEPTH=4) -> out_stall rises when count reaches 3. A 4th cycle of dual requests sets out_overflow=1 and drops the mem request. out_overflow holds until reset.
4. Enqueue {9,0x1111} then {9,0x2222}; read_reg_1_add=9, in_reg_1_val=0x0000 -> out_fwd_1_val=0x2222 while both are pending, 0x2222 after the first drains, and passes in_reg_1_val once empty.
5. read_reg_2_add=4 with no pending write to 4, in_reg_2_val=0x5A5A -> out_fwd_2_val=0x5A5A; ALU request to 4 in the same cycle does not change it that cycle.
6. FIFO holding 3 entries, in_rst=1 for one edge -> out_write_en=0, out_stall=0, out_overflow=0 immediately after; no pending entry ever appears on the write port.
